// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI RAM command controller:
// command encoding, FSM state encoding and frame geometry.
package spi_ram_pkg;

   localparam int FRAME_W   = 10;
   localparam int PAYLOAD_W = 8;

   // Bit positions of the one-hot arbiter grant
   localparam int GNT_SPI   = 0;
   localparam int GNT_HOST  = 1;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RDWAIT = 2'b10
   } state_e;

endpackage

// File: rtl/spi_ram_rr_arb.sv
// Two-requester round-robin arbiter (SPI vs host) for the single RAM port.
// Grant is combinational and one-hot; history only advances when the
// controller consumes the grant (FSM in IDLE).
module spi_ram_rr_arb
   import spi_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_spi,
   input  logic       req_host,
   input  logic       consume,
   output logic [1:0] gnt
);

   logic last_host_r;   // last served requester was the host
   logic hist_valid_r;  // at least one grant since reset; until then SPI wins ties

   // One-hot grant: lone requester wins, ties go to the one not served last
   always_comb begin
      gnt = 2'b00;
      if (req_spi && req_host) begin
         if (hist_valid_r && !last_host_r) begin
            gnt[GNT_HOST] = 1'b1;
         end else begin
            gnt[GNT_SPI] = 1'b1;
         end
      end else if (req_spi) begin
         gnt[GNT_SPI] = 1'b1;
      end else if (req_host) begin
         gnt[GNT_HOST] = 1'b1;
      end else begin
         gnt = 2'b00;
      end
   end

   // Remember who was served whenever a grant is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_host_r  <= 1'b0;
         hist_valid_r <= 1'b0;
      end else if (consume && (gnt != 2'b00)) begin
         last_host_r  <= gnt[GNT_HOST];
         hist_valid_r <= 1'b1;
      end
   end

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI command controller and RAM-port arbiter. Decodes 10-bit SPI frames
// ({cmd[1:0], payload[7:0]}), keeps write/read address registers and shares
// one synchronous RAM port round-robin between SPI and a host port.
// Optional: define SPI_RAM_CTRL_AUTOINC_EN to post-increment the SPI write/read
// address after every SPI data access.
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [9:0]         rx_data,
   input  logic               rx_valid,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               host_req,
   input  logic               host_we,
   input  logic [ADDR_W-1:0]  host_addr,
   input  logic [DATA_W-1:0]  host_wdata,
   output logic               host_gnt,
   output logic               host_rvalid,
   output logic [DATA_W-1:0]  host_rdata,
   output logic               mem_en,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               busy
);

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   state_e              state_r, state_nxt_s;
   logic                rx_valid_r;
   logic [ADDR_W-1:0]   wr_addr_r, rd_addr_r, wr_addr_nxt_s, rd_addr_nxt_s;
   logic [ADDR_W-1:0]   wr_base_s, rd_base_s;
   logic                pend_r, pend_we_r, pend_nxt_s, pend_we_nxt_s;
   logic [ADDR_W-1:0]   pend_addr_r, pend_addr_nxt_s;
   logic [DATA_W-1:0]   pend_data_r, pend_data_nxt_s;
   logic                srv_host_r, srv_host_nxt_s;
   logic                mem_en_r, mem_we_r, mem_en_nxt_s, mem_we_nxt_s;
   logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
   logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_nxt_s;
   logic                host_gnt_r, host_gnt_nxt_s;
   logic [7:0]          tx_data_r, tx_data_nxt_s;
   logic                tx_valid_r, tx_valid_nxt_s;
   logic [DATA_W-1:0]   host_rdata_r, host_rdata_nxt_s;
   logic                host_rvalid_r, host_rvalid_nxt_s;
   logic                busy_r, busy_nxt_s;
   logic                accept_s, consume_s;
   cmd_e                cmd_s;
   logic [PAYLOAD_W-1:0] payload_s;
   logic [1:0]          gnt_s;

   // A frame counts once, on the rising edge of the rx_valid level
   assign accept_s  = rx_valid & ~rx_valid_r;
   assign cmd_s     = cmd_e'(rx_data[FRAME_W-1:FRAME_W-2]);
   assign payload_s = rx_data[PAYLOAD_W-1:0];
   assign consume_s = (state_r == ST_IDLE);
   assign busy_nxt_s = (state_nxt_s != ST_IDLE) | pend_nxt_s;

   spi_ram_rr_arb u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_spi  (pend_r),
      .req_host (host_req),
      .consume  (consume_s),
      .gnt      (gnt_s)
   );

   // Address registers, optional post-access increment, single pending SPI access
   always_comb begin
      wr_base_s = wr_addr_r;
      rd_base_s = rd_addr_r;
`ifdef SPI_RAM_CTRL_AUTOINC_EN
      if ((state_r == ST_ACCESS) && !srv_host_r) begin
         if (mem_we_r) begin
            wr_base_s = wr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
         end else begin
            rd_base_s = rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
         end
      end else begin
         wr_base_s = wr_addr_r;
         rd_base_s = rd_addr_r;
      end
`endif
      wr_addr_nxt_s   = wr_base_s;
      rd_addr_nxt_s   = rd_base_s;
      pend_we_nxt_s   = pend_we_r;
      pend_addr_nxt_s = pend_addr_r;
      pend_data_nxt_s = pend_data_r;
      if (consume_s && gnt_s[GNT_SPI]) begin
         pend_nxt_s = 1'b0;
      end else begin
         pend_nxt_s = pend_r;
      end
      // A new frame wins over the clear; the access address is frozen here
      if (accept_s) begin
         case (cmd_s)
            CMD_WR_ADDR: wr_addr_nxt_s = ADDR_W'(payload_s);
            CMD_WR_DATA: begin
               pend_nxt_s      = 1'b1;
               pend_we_nxt_s   = 1'b1;
               pend_addr_nxt_s = wr_base_s;
               pend_data_nxt_s = DATA_W'(payload_s);
            end
            CMD_RD_ADDR: rd_addr_nxt_s = ADDR_W'(payload_s);
            CMD_RD_DATA: begin
               pend_nxt_s      = 1'b1;
               pend_we_nxt_s   = 1'b0;
               pend_addr_nxt_s = rd_base_s;
               pend_data_nxt_s = DATA_ZERO;
            end
            default:     wr_addr_nxt_s = wr_base_s;
         endcase
      end else begin
         wr_addr_nxt_s = wr_base_s;
      end
   end

   // FSM next state and next values of every registered output
   always_comb begin
      state_nxt_s       = state_r;
      srv_host_nxt_s    = srv_host_r;
      mem_en_nxt_s      = 1'b0;
      mem_we_nxt_s      = 1'b0;
      mem_addr_nxt_s    = ADDR_ZERO;
      mem_wdata_nxt_s   = DATA_ZERO;
      host_gnt_nxt_s    = 1'b0;
      tx_valid_nxt_s    = 1'b0;
      tx_data_nxt_s     = tx_data_r;
      host_rvalid_nxt_s = 1'b0;
      host_rdata_nxt_s  = host_rdata_r;
      case (state_r)
         ST_IDLE: begin
            if (gnt_s[GNT_HOST]) begin
               state_nxt_s     = ST_ACCESS;
               srv_host_nxt_s  = 1'b1;
               mem_en_nxt_s    = 1'b1;
               mem_we_nxt_s    = host_we;
               mem_addr_nxt_s  = host_addr;
               mem_wdata_nxt_s = host_we ? host_wdata : DATA_ZERO;
               host_gnt_nxt_s  = 1'b1;
            end else if (gnt_s[GNT_SPI]) begin
               state_nxt_s     = ST_ACCESS;
               srv_host_nxt_s  = 1'b0;
               mem_en_nxt_s    = 1'b1;
               mem_we_nxt_s    = pend_we_r;
               mem_addr_nxt_s  = pend_addr_r;
               mem_wdata_nxt_s = pend_we_r ? pend_data_r : DATA_ZERO;
            end else begin
               state_nxt_s     = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (mem_we_r) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RDWAIT;
            end
         end
         ST_RDWAIT: begin
            state_nxt_s = ST_IDLE;
            if (srv_host_r) begin
               host_rdata_nxt_s  = mem_rdata;
               host_rvalid_nxt_s = 1'b1;
            end else begin
               tx_data_nxt_s     = 8'(mem_rdata);
               tx_valid_nxt_s    = 1'b1;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // All state and outputs registered; async reset aborts any access silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         rx_valid_r    <= 1'b0;
         wr_addr_r     <= ADDR_ZERO;
         rd_addr_r     <= ADDR_ZERO;
         pend_r        <= 1'b0;
         pend_we_r     <= 1'b0;
         pend_addr_r   <= ADDR_ZERO;
         pend_data_r   <= DATA_ZERO;
         srv_host_r    <= 1'b0;
         mem_en_r      <= 1'b0;
         mem_we_r      <= 1'b0;
         mem_addr_r    <= ADDR_ZERO;
         mem_wdata_r   <= DATA_ZERO;
         host_gnt_r    <= 1'b0;
         tx_data_r     <= 8'h00;
         tx_valid_r    <= 1'b0;
         host_rdata_r  <= DATA_ZERO;
         host_rvalid_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         rx_valid_r    <= rx_valid;
         wr_addr_r     <= wr_addr_nxt_s;
         rd_addr_r     <= rd_addr_nxt_s;
         pend_r        <= pend_nxt_s;
         pend_we_r     <= pend_we_nxt_s;
         pend_addr_r   <= pend_addr_nxt_s;
         pend_data_r   <= pend_data_nxt_s;
         srv_host_r    <= srv_host_nxt_s;
         mem_en_r      <= mem_en_nxt_s;
         mem_we_r      <= mem_we_nxt_s;
         mem_addr_r    <= mem_addr_nxt_s;
         mem_wdata_r   <= mem_wdata_nxt_s;
         host_gnt_r    <= host_gnt_nxt_s;
         tx_data_r     <= tx_data_nxt_s;
         tx_valid_r    <= tx_valid_nxt_s;
         host_rdata_r  <= host_rdata_nxt_s;
         host_rvalid_r <= host_rvalid_nxt_s;
         busy_r        <= busy_nxt_s;
      end
   end

   assign tx_data     = tx_data_r;
   assign tx_valid    = tx_valid_r;
   assign host_gnt    = host_gnt_r;
   assign host_rvalid = host_rvalid_r;
   assign host_rdata  = host_rdata_r;
   assign mem_en      = mem_en_r;
   assign mem_we      = mem_we_r;
   assign mem_addr    = mem_addr_r;
   assign mem_wdata   = mem_wdata_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: expected RAM accesses, SPI read data and
// host read data are queued by the stimulus; a monitor process pops and
// compares whenever the DUT presents mem_en, tx_valid or host_rvalid.
// Expected values follow SPI_RAM_CTRL_AUTOINC_EN when it is defined.
module tb_spi_ram_ctrl;

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
      logic       host;
      int         cyc;
   } mem_exp_t;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } rd_exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [9:0] rx_data = 10'h000;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       host_req = 1'b0;
   logic       host_we = 1'b0;
   logic [7:0] host_addr = 8'h00;
   logic [7:0] host_wdata = 8'h00;
   logic       host_gnt;
   logic       host_rvalid;
   logic [7:0] host_rdata;
   logic       mem_en;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic       busy;

   logic [7:0] tb_mem [256];
   mem_exp_t   mem_q [$];
   rd_exp_t    tx_q  [$];
   rd_exp_t    hrd_q [$];
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   spi_ram_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .host_req(host_req),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk32(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected pulse at cycle %0d, got 1 expected 0", name, cyc);
   endtask

   task automatic exp_mem(input logic we, input logic [7:0] addr, input logic [7:0] data,
                          input logic host, input int c);
      mem_exp_t e;
      e.we = we; e.addr = addr; e.data = data; e.host = host; e.cyc = c;
      mem_q.push_back(e);
   endtask

   task automatic exp_tx(input logic [7:0] data, input int c);
      rd_exp_t e;
      e.data = data; e.cyc = c;
      tx_q.push_back(e);
   endtask

   task automatic exp_hrd(input logic [7:0] data);
      rd_exp_t e;
      e.data = data; e.cyc = -1;
      hrd_q.push_back(e);
   endtask

   task automatic cycle_count();
      forever begin
         @(posedge clk);
         cyc <= cyc + 1;
      end
   endtask

   task automatic ram_model();
      forever begin
         @(posedge clk);
         if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
         end
      end
   endtask

   task automatic monitor();
      mem_exp_t me;
      rd_exp_t  re;
      forever begin
         @(negedge clk);
         if (mem_en) begin
            if (mem_q.size() == 0) begin
               fail_now("mem_en");
            end else begin
               me = mem_q.pop_front();
               chk1("mem_we", mem_we, me.we);
               chk8("mem_addr", mem_addr, me.addr);
               if (me.we) chk8("mem_wdata", mem_wdata, me.data);
               chk1("host_gnt", host_gnt, me.host);
               if (me.cyc >= 0) chk32("mem_cycle", cyc, me.cyc);
            end
         end else if (host_gnt) begin
            fail_now("host_gnt");
         end
         if (tx_valid) begin
            if (tx_q.size() == 0) begin
               fail_now("tx_valid");
            end else begin
               re = tx_q.pop_front();
               chk8("tx_data", tx_data, re.data);
               if (re.cyc >= 0) chk32("tx_cycle", cyc, re.cyc);
            end
         end
         if (host_rvalid) begin
            if (hrd_q.size() == 0) begin
               fail_now("host_rvalid");
            end else begin
               re = hrd_q.pop_front();
               chk8("host_rdata", host_rdata, re.data);
            end
         end
      end
   endtask

   task automatic watchdog();
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   endtask

   // One frame; hold = cycles rx_valid stays high; ce = cycle number after acceptance edge
   task automatic send_frame(input logic [9:0] f, input int hold, output int ce);
      @(negedge clk);
      rx_data = f;
      rx_valid = 1'b1;
      ce = cyc + 1;
      repeat (hold) @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && (k < 60));
      chk1("idle_reached", busy, 1'b0);
   endtask

   task automatic wait_gnt();
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (host_gnt) break;
      end
      chk1("host_gnt_seen", host_gnt, 1'b1);
      host_req = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk8({tag, "_tx_data"}, tx_data, 8'h00);
      chk1({tag, "_tx_valid"}, tx_valid, 1'b0);
      chk1({tag, "_host_gnt"}, host_gnt, 1'b0);
      chk1({tag, "_host_rvalid"}, host_rvalid, 1'b0);
      chk8({tag, "_host_rdata"}, host_rdata, 8'h00);
      chk1({tag, "_mem_en"}, mem_en, 1'b0);
      chk1({tag, "_mem_we"}, mem_we, 1'b0);
      chk8({tag, "_mem_addr"}, mem_addr, 8'h00);
      chk8({tag, "_mem_wdata"}, mem_wdata, 8'h00);
      chk1({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      int ce;
      for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i) ^ 8'h5A;
      fork
         cycle_count();
         ram_model();
         monitor();
         watchdog();
      join_none

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("reset");

      // Collision right after reset: SPI read wins, then a second SPI read
      // collides with the still-waiting host write and the host wins.
      send_frame(10'h220, 1, ce);
      wait_idle();
      exp_mem(1'b0, 8'h20, 8'h00, 1'b0, -1);
      exp_mem(1'b1, 8'h10, 8'h55, 1'b1, -1);
      exp_tx(8'h7A, -1);
`ifdef SPI_RAM_CTRL_AUTOINC_EN
      exp_mem(1'b0, 8'h21, 8'h00, 1'b0, -1);
      exp_tx(8'h7B, -1);
`else
      exp_mem(1'b0, 8'h20, 8'h00, 1'b0, -1);
      exp_tx(8'h7A, -1);
`endif
      @(negedge clk);
      rx_data = 10'h300; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h55;
      @(negedge clk);
      rx_data = 10'h300; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      wait_gnt();
      wait_idle();

      // Host read-back of its own write
      exp_mem(1'b0, 8'h10, 8'h00, 1'b1, -1);
      exp_hrd(8'h55);
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; host_wdata = 8'h00;
      wait_gnt();
      wait_idle();

      // SPI write 0xA5 to 0x3C, then read it back with exact latency
      send_frame(10'h03C, 1, ce);
      wait_idle();
      send_frame(10'h1A5, 1, ce);
      exp_mem(1'b1, 8'h3C, 8'hA5, 1'b0, ce + 1);
      wait_idle();
      send_frame(10'h23C, 1, ce);
      wait_idle();
      send_frame(10'h300, 1, ce);
      exp_mem(1'b0, 8'h3C, 8'h00, 1'b0, ce + 1);
      exp_tx(8'hA5, ce + 3);
      wait_idle();

      // rx_valid held for 12 cycles -> exactly one write
`ifdef SPI_RAM_CTRL_AUTOINC_EN
      exp_mem(1'b1, 8'h3D, 8'hA5, 1'b0, -1);
`else
      exp_mem(1'b1, 8'h3C, 8'hA5, 1'b0, -1);
`endif
      send_frame(10'h1A5, 12, ce);
      wait_idle();
      repeat (3) @(negedge clk);

      // Address auto-increment boundary 0xFF -> 0x00
      send_frame(10'h0FF, 1, ce);
      wait_idle();
      send_frame(10'h111, 1, ce);
      exp_mem(1'b1, 8'hFF, 8'h11, 1'b0, ce + 1);
      wait_idle();
      send_frame(10'h122, 1, ce);
`ifdef SPI_RAM_CTRL_AUTOINC_EN
      exp_mem(1'b1, 8'h00, 8'h22, 1'b0, ce + 1);
      wait_idle();
      chk8("ram_ff", tb_mem[8'hFF], 8'h11);
      chk8("ram_00", tb_mem[8'h00], 8'h22);
`else
      exp_mem(1'b1, 8'hFF, 8'h22, 1'b0, ce + 1);
      wait_idle();
      chk8("ram_ff", tb_mem[8'hFF], 8'h22);
      chk8("ram_00", tb_mem[8'h00], 8'h5A);
`endif

      // Reset during RDWAIT: read is issued, but no tx_valid may follow
      send_frame(10'h240, 1, ce);
      wait_idle();
      send_frame(10'h300, 1, ce);
      exp_mem(1'b0, 8'h40, 8'h00, 1'b0, ce + 1);
      @(negedge clk);
      @(negedge clk);
      chk1("busy_rdwait", busy, 1'b1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("midreset");
      repeat (5) @(negedge clk);

      chk32("mem_q_empty", mem_q.size(), 0);
      chk32("tx_q_empty", tx_q.size(), 0);
      chk32("hrd_q_empty", hrd_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
